minibyte_bus_arbiter: RTL and testbench

Shares the single external 8-bit address/data bus (address out, data out, data in, write-enable) between two requesters.
- Requester 0: minibyte CPU.
- Requester 1: program loader / debug port.
- Arbitration is round-robin, with a req/gnt/ack handshake and a parameterised number of wait states per access.
- Sits between the requesters and the top-level pins.

---
 rtl/minibyte_bus_pkg.sv | 17 +
 rtl/minibyte_rr_picker.sv | 27 ++
 rtl/minibyte_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_minibyte_bus_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/minibyte_bus_pkg.sv
// Shared definitions for the minibyte external bus arbiter: bus widths,
// FSM state encoding and requester IDs.
package minibyte_bus_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/minibyte_rr_picker.sv
// Combinational 2-way round-robin picker: the requester that was not
// granted last wins a tie; lock_mask removes requesters from consideration.
module minibyte_rr_picker
   import minibyte_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic [1:0] lock_mask,
   output logic       valid,
   output logic       winner
);

   logic [1:0] eligible;

   assign eligible = req & lock_mask;

   always_comb begin
      valid  = |eligible;
      winner = REQ_CPU;
      if (&eligible) begin
         winner = ~last_grant;
      end else if (eligible[1]) begin
         winner = REQ_LDR;
      end
   end

endmodule

// File: rtl/minibyte_bus_arbiter.sv
// Round-robin owner of the single external 8-bit bus shared by the CPU and
// the loader/debug port. Optional bus locking: define MINIBYTE_ARB_LOCK_EN.
module minibyte_bus_arbiter
   import minibyte_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int CNT_W       = 4
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              req_0,
   input  logic              req_1,
   input  logic [ADDR_W-1:0] addr_0,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [DATA_W-1:0] wdata_0,
   input  logic [DATA_W-1:0] wdata_1,
   input  logic              we_0,
   input  logic              we_1,
   input  logic              lock_0,
   input  logic              lock_1,
   output logic              gnt_0,
   output logic              gnt_1,
   output logic              ack_0,
   output logic              ack_1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] bus_addr_out,
   output logic [DATA_W-1:0] bus_data_out,
   output logic              bus_we_out,
   input  logic [DATA_W-1:0] bus_data_in
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_ACCESS = ACCESS;
   localparam logic [1:0] ST_DONE   = DONE;

   logic [1:0]        state;
   logic              owner;
   logic              last_grant;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic [DATA_W-1:0] rdata_q;

   logic [1:0]        lock_mask;
   logic              pick_valid;
   logic              pick_winner;
   logic              in_access;
   logic              in_done;

`ifdef MINIBYTE_ARB_LOCK_EN
   logic lock_flag;
   logic owner_lock;

   // The lock only holds while the owner keeps its lock line up, so an IDLE
   // cycle with the line low releases the bus in that same cycle.
   assign owner_lock = (owner == REQ_LDR) ? lock_1 : lock_0;
   assign lock_mask  = (lock_flag && owner_lock) ?
                       ((owner == REQ_LDR) ? 2'b10 : 2'b01) : 2'b11;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         lock_flag <= 1'b0;
      end else if (state == ST_DONE) begin
         lock_flag <= owner_lock;
      end else if (state == ST_IDLE && !owner_lock) begin
         lock_flag <= 1'b0;
      end
   end
`else
   logic unused_lock;

   assign unused_lock = lock_0 ^ lock_1;
   assign lock_mask   = 2'b11;
`endif

   minibyte_rr_picker u_picker (
      .req        ({req_1, req_0}),
      .last_grant (last_grant),
      .lock_mask  (lock_mask),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

   // The winner's request is latched in IDLE so the requester-side inputs
   // are don't-care for the rest of the transaction.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state      <= ST_IDLE;
         owner      <= REQ_CPU;
         last_grant <= REQ_LDR;
         cnt        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         rdata_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  owner   <= pick_winner;
                  addr_q  <= (pick_winner == REQ_LDR) ? addr_1  : addr_0;
                  wdata_q <= (pick_winner == REQ_LDR) ? wdata_1 : wdata_0;
                  we_q    <= (pick_winner == REQ_LDR) ? we_1    : we_0;
                  cnt     <= CNT_W'(WAIT_CYCLES);
                  state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  rdata_q    <= bus_data_in;
                  last_grant <= owner;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_access = (state == ST_ACCESS);
   assign in_done   = (state == ST_DONE);

   assign bus_addr_out = in_access ? addr_q  : '0;
   assign bus_data_out = in_access ? wdata_q : '0;
   assign bus_we_out   = in_access && we_q;

   assign gnt_0 = (in_access || in_done) && (owner == REQ_CPU);
   assign gnt_1 = (in_access || in_done) && (owner == REQ_LDR);
   assign ack_0 = in_done && (owner == REQ_CPU);
   assign ack_1 = in_done && (owner == REQ_LDR);
   assign rdata = rdata_q;

endmodule

// File: tb/tb_minibyte_bus_arbiter.sv
// Self-checking bench for minibyte_bus_arbiter with WAIT_CYCLES=1; the lock
// sequence runs only when MINIBYTE_ARB_LOCK_EN is defined.
module tb_minibyte_bus_arbiter;

   localparam int WAITS = 1;

   typedef struct {
      logic       id;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       we;
      logic [7:0] din;
      logic [7:0] exp_addr;
      logic [7:0] exp_dout;
      logic       exp_we;
      logic [7:0] exp_rdata;
   } vec_t;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       req_0, req_1;
   logic [7:0] addr_0, addr_1, wdata_0, wdata_1;
   logic       we_0, we_1, lock_0, lock_1;
   logic       gnt_0, gnt_1, ack_0, ack_1;
   logic [7:0] rdata, bus_addr_out, bus_data_out, bus_data_in;
   logic       bus_we_out;

   int n_checks = 0;
   int n_fails  = 0;

   vec_t vecs [4];

   always #5 clk_in = ~clk_in;

   minibyte_bus_arbiter #(.WAIT_CYCLES(WAITS), .CNT_W(4)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .req_0        (req_0),
      .req_1        (req_1),
      .addr_0       (addr_0),
      .addr_1       (addr_1),
      .wdata_0      (wdata_0),
      .wdata_1      (wdata_1),
      .we_0         (we_0),
      .we_1         (we_1),
      .lock_0       (lock_0),
      .lock_1       (lock_1),
      .gnt_0        (gnt_0),
      .gnt_1        (gnt_1),
      .ack_0        (ack_0),
      .ack_1        (ack_1),
      .rdata        (rdata),
      .bus_addr_out (bus_addr_out),
      .bus_data_out (bus_data_out),
      .bus_we_out   (bus_we_out),
      .bus_data_in  (bus_data_in)
   );

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear_inputs();
      req_0 = 0; req_1 = 0; addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0;
      we_0 = 0; we_1 = 0; lock_0 = 0; lock_1 = 0;
   endtask

   // One complete transaction: WAITS+1 ACCESS cycles, the DONE cycle, then IDLE.
   task automatic applyStimulus(input int idx, input vec_t v);
      logic [1:0] g;
      g = v.id ? 2'b10 : 2'b01;
      clear_inputs();
      bus_data_in = v.din;
      if (v.id) begin
         req_1 = 1; addr_1 = v.addr; wdata_1 = v.wdata; we_1 = v.we;
      end else begin
         req_0 = 1; addr_0 = v.addr; wdata_0 = v.wdata; we_0 = v.we;
      end
      for (int c = 0; c <= WAITS; c++) begin
         tick();
         checkOutput($sformatf("v%0d_acc%0d_addr", idx, c), 16'(bus_addr_out), 16'(v.exp_addr));
         checkOutput($sformatf("v%0d_acc%0d_dout", idx, c), 16'(bus_data_out), 16'(v.exp_dout));
         checkOutput($sformatf("v%0d_acc%0d_we", idx, c), 16'(bus_we_out), 16'(v.exp_we));
         checkOutput($sformatf("v%0d_acc%0d_gnt", idx, c), 16'({gnt_1, gnt_0}), 16'(g));
         checkOutput($sformatf("v%0d_acc%0d_ack", idx, c), 16'({ack_1, ack_0}), 16'd0);
      end
      tick();
      checkOutput($sformatf("v%0d_done_ack", idx), 16'({ack_1, ack_0}), 16'(g));
      checkOutput($sformatf("v%0d_done_gnt", idx), 16'({gnt_1, gnt_0}), 16'(g));
      checkOutput($sformatf("v%0d_done_rdata", idx), 16'(rdata), 16'(v.exp_rdata));
      checkOutput($sformatf("v%0d_done_bus", idx), 16'({bus_we_out, bus_addr_out}), 16'd0);
      req_0 = 0; req_1 = 0;
      bus_data_in = 8'hEE;
      tick();
      checkOutput($sformatf("v%0d_idle_gntack", idx), 16'({gnt_1, gnt_0, ack_1, ack_0}), 16'd0);
      checkOutput($sformatf("v%0d_idle_rdata_hold", idx), 16'(rdata), 16'(v.exp_rdata));
   endtask

   initial begin
      // id, addr, wdata, we, din, exp_addr, exp_dout, exp_we, exp_rdata
      vecs[0] = '{1'b0, 8'h3C, 8'h00, 1'b0, 8'hA5, 8'h3C, 8'h00, 1'b0, 8'hA5};
      vecs[1] = '{1'b1, 8'h10, 8'h5A, 1'b1, 8'h77, 8'h10, 8'h5A, 1'b1, 8'h77};
      vecs[2] = '{1'b0, 8'hFF, 8'hC3, 1'b1, 8'h00, 8'hFF, 8'hC3, 1'b1, 8'h00};
      vecs[3] = '{1'b1, 8'h00, 8'h81, 1'b0, 8'hFF, 8'h00, 8'h81, 1'b0, 8'hFF};

      clear_inputs();
      bus_data_in = 8'h99;
      rst_in = 1;
      req_0 = 1;
      addr_0 = 8'h55;
      we_0 = 1;
      tick();
      tick();
      checkOutput("rst_gntack", 16'({gnt_1, gnt_0, ack_1, ack_0}), 16'd0);
      checkOutput("rst_rdata", 16'(rdata), 16'd0);
      checkOutput("rst_bus_addr", 16'(bus_addr_out), 16'd0);
      checkOutput("rst_bus_dout", 16'(bus_data_out), 16'd0);
      checkOutput("rst_bus_we", 16'(bus_we_out), 16'd0);
      clear_inputs();
      rst_in = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("post_rst%0d_we", c), 16'(bus_we_out), 16'd0);
         checkOutput($sformatf("post_rst%0d_gnt", c), 16'({gnt_1, gnt_0}), 16'd0);
      end

      for (int i = 0; i < 4; i++) begin
         applyStimulus(i, vecs[i]);
      end

      // Reset in the second ACCESS cycle of a write abandons it silently.
      clear_inputs();
      req_1 = 1; addr_1 = 8'h10; wdata_1 = 8'h5A; we_1 = 1;
      tick();
      tick();
      checkOutput("midrst_acc2_we", 16'(bus_we_out), 16'd1);
      rst_in = 1;
      req_1 = 0;
      tick();
      checkOutput("midrst_we", 16'(bus_we_out), 16'd0);
      checkOutput("midrst_gntack", 16'({gnt_1, gnt_0, ack_1, ack_0}), 16'd0);
      rst_in = 0;
      for (int c = 0; c < 2; c++) begin
         tick();
         checkOutput($sformatf("midrst_after%0d", c),
                     16'({gnt_1, gnt_0, ack_1, ack_0, bus_we_out}), 16'd0);
      end

      // Continuous contention right after reset: 0,1,0,1 at 4 cycles each.
      clear_inputs();
      bus_data_in = 8'h12;
      req_0 = 1; addr_0 = 8'h21;
      req_1 = 1; addr_1 = 8'h42;
      for (int t = 0; t < 4; t++) begin
         logic [1:0] g;
         g = (t % 2) ? 2'b10 : 2'b01;
         tick();
         checkOutput($sformatf("cont%0d_gnt", t), 16'({gnt_1, gnt_0}), 16'(g));
         checkOutput($sformatf("cont%0d_addr", t), 16'(bus_addr_out),
                     (t % 2) ? 16'h0042 : 16'h0021);
         tick();
         tick();
         checkOutput($sformatf("cont%0d_ack", t), 16'({ack_1, ack_0}), 16'(g));
         tick();
         checkOutput($sformatf("cont%0d_idle", t), 16'({gnt_1, gnt_0}), 16'd0);
      end
      clear_inputs();

`ifdef MINIBYTE_ARB_LOCK_EN
      rst_in = 1;
      tick();
      rst_in = 0;
      req_0 = 1; lock_0 = 1; addr_0 = 8'h33;
      req_1 = 1; addr_1 = 8'h44;
      for (int t = 0; t < 3; t++) begin
         logic [1:0] g;
         g = (t < 2) ? 2'b01 : 2'b10;
         tick();
         checkOutput($sformatf("lock%0d_gnt", t), 16'({gnt_1, gnt_0}), 16'(g));
         tick();
         tick();
         checkOutput($sformatf("lock%0d_ack", t), 16'({ack_1, ack_0}), 16'(g));
         if (t == 1) lock_0 = 0;
         tick();
      end
      clear_inputs();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
